// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception controller: MIPS ExcCode values,
// the default general exception vector, the flush counter width and the
// controller FSM states.
package exc_ctrl_pkg;

  // ExcCode values written to CP0 Cause.ExcCode
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  // General exception entry point (BEV=1 boot vector + 0x180)
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;

  // Flush down-counter width; supports flush lengths 1..15
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  // Interrupt is pending when IE=1, EXL=0 and an unmasked IP bit is set.
  function automatic logic irq_pending(input logic [31:0] status,
                                       input logic [31:0] cause);
    return status[0] & ~status[1] & (|(cause[15:8] & status[15:8]));
  endfunction

endpackage

// File: rtl/exc_ctrl_prio.sv
// Fixed-priority selector for the exception controller. Purely
// combinational: picks the winning cause among interrupt, synchronous
// exceptions and eret, and reports its ExcCode.
// Priority: interrupt > AdEL > AdES > Ov > Sys > Bp > eret.
module exc_prio
  import exc_ctrl_pkg::*;
(
  input  logic       int_pending_i,
  input  logic       adel_i,
  input  logic       ades_i,
  input  logic       overflow_i,
  input  logic       syscall_i,
  input  logic       break_i,
  input  logic       eret_i,
  output logic       valid_o,
  output logic       is_eret_o,
  output logic [4:0] exccode_o
);

  // Priority chain: first matching cause wins.
  always_comb begin
    // NOTE: every output gets a default before the if-chain so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    valid_o   = 1'b1;
    is_eret_o = 1'b0;
    exccode_o = EXC_INT;
    if (int_pending_i) begin
      exccode_o = EXC_INT;
    end else if (adel_i) begin
      exccode_o = EXC_ADEL;
    end else if (ades_i) begin
      exccode_o = EXC_ADES;
    end else if (overflow_i) begin
      exccode_o = EXC_OV;
    end else if (syscall_i) begin
      exccode_o = EXC_SYS;
    end else if (break_i) begin
      exccode_o = EXC_BP;
    end else if (eret_i) begin
      is_eret_o = 1'b1;
    end else begin
      valid_o = 1'b0;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception / eret controller for the MEM stage. On an event it issues a
// one-cycle commit pulse to CP0, flushes the pipeline for FLUSH_CYCLES
// cycles, then holds a valid/ready redirect to fetch until accepted.
// Configuration: define EXC_CTRL_INT_EN to enable interrupt detection;
// without it only synchronous exceptions and eret are handled.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = exc_ctrl_pkg::EXC_VECTOR_DEFAULT,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic        syscall_i,
  input  logic        break_i,
  input  logic        overflow_i,
  input  logic        adel_i,
  input  logic        ades_i,
  input  logic        eret_i,
  input  logic        delayslot_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  output logic        exc_commit_o,
  output logic [4:0]  exccode_o,
  output logic        eret_commit_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  input  logic        redirect_ready_i
);

  import exc_ctrl_pkg::*;

  // Counter is loaded with FLUSH_CYCLES-1 and the FSM leaves FLUSH when it
  // reads zero, giving exactly FLUSH_CYCLES flush cycles.
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      target_q, target_d;

  logic             int_pending;
  logic             prio_valid;
  logic             prio_is_eret;
  logic [4:0]       prio_code;
  logic             event_valid;

  // delayslot_i and pc_i are passed to CP0 by the top level, and only a
  // few Status/Cause bits matter here; fold the rest into a sink.
  logic             unused_inputs;
  assign unused_inputs = ^{delayslot_i, pc_i, status_i, cause_i};

`ifdef EXC_CTRL_INT_EN
  assign int_pending = irq_pending(status_i, cause_i);
`else
  assign int_pending = 1'b0;
`endif

  exc_prio u_prio (
    .int_pending_i (int_pending),
    .adel_i        (mem_valid_i & adel_i),
    .ades_i        (mem_valid_i & ades_i),
    .overflow_i    (mem_valid_i & overflow_i),
    .syscall_i     (mem_valid_i & syscall_i),
    .break_i       (mem_valid_i & break_i),
    .eret_i        (mem_valid_i & eret_i),
    .valid_o       (prio_valid),
    .is_eret_o     (prio_is_eret),
    .exccode_o     (prio_code)
  );

  // Suppress events while reset is asserted so no commit pulse escapes
  // during a reset cycle.
  assign event_valid = prio_valid & ~rst;

  // State, flush counter and redirect target registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value, independent of statement order.
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    target_d         = target_q;
    exc_commit_o     = 1'b0;
    exccode_o        = 5'h00;
    eret_commit_o    = 1'b0;
    flush_o          = 1'b0;
    stall_o          = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = 32'h0;

    unique case (state_q)
      ST_IDLE: begin
        if (event_valid) begin
          state_d = ST_FLUSH;
          cnt_d   = FLUSH_LOAD;
          if (prio_is_eret) begin
            eret_commit_o = 1'b1;
            target_d      = epc_i;
          end else begin
            exc_commit_o  = 1'b1;
            exccode_o     = prio_code;
            target_d      = EXC_VECTOR;
          end
        end
      end

      ST_FLUSH: begin
        flush_o = 1'b1;
        stall_o = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_REDIRECT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_REDIRECT: begin
        stall_o          = 1'b1;
        redirect_valid_o = 1'b1;
        redirect_pc_o    = target_q;
        if (redirect_ready_i) begin
          state_d  = ST_IDLE;
          target_d = 32'h0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: a table of single-event vectors,
// hand-written multi-cycle sequences, and a randomized run against a
// cycle-level reference model of the event/flush/redirect timeline.
module tb_exc_ctrl;

  localparam int          FC  = 2;
  localparam logic [31:0] VEC = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, syscall, brk, ovf, adel, ades, eret, dslot;
  logic [31:0] pc, status, cause, epc;
  logic        exc_commit, eret_commit, flush, stall, rvalid, rready;
  logic [4:0]  exccode;
  logic [31:0] rpc;

  int cmp_cnt  = 0;
  int fail_cnt = 0;

  // Reference model: remaining flush cycles, redirect pending, target.
  int          m_flush_left;
  bit          m_redir;
  logic [31:0] m_target;

  always #5 clk = ~clk;

  exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_valid_i      (mem_valid),
    .syscall_i        (syscall),
    .break_i          (brk),
    .overflow_i       (ovf),
    .adel_i           (adel),
    .ades_i           (ades),
    .eret_i           (eret),
    .delayslot_i      (dslot),
    .pc_i             (pc),
    .status_i         (status),
    .cause_i          (cause),
    .epc_i            (epc),
    .exc_commit_o     (exc_commit),
    .exccode_o        (exccode),
    .eret_commit_o    (eret_commit),
    .flush_o          (flush),
    .stall_o          (stall),
    .redirect_valid_o (rvalid),
    .redirect_pc_o    (rpc),
    .redirect_ready_i (rready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Winning cause from the current inputs, walked in priority order.
  function automatic void model_event(output bit v, output bit er, output logic [4:0] code);
    bit          f[6];
    logic [4:0]  c[6];
    bit          ip;
    ip = 1'b0;
`ifdef EXC_CTRL_INT_EN
    ip = status[0] && !status[1] && ((cause[15:8] & status[15:8]) != 0);
`endif
    f = '{ip, mem_valid && adel, mem_valid && ades, mem_valid && ovf,
          mem_valid && syscall, mem_valid && brk};
    c = '{5'h00, 5'h04, 5'h05, 5'h0C, 5'h08, 5'h09};
    v = 1'b0; er = 1'b0; code = 5'h00;
    for (int i = 0; i < 6; i++) begin
      if (f[i]) begin
        v = 1'b1; code = c[i];
        return;
      end
    end
    if (mem_valid && eret) begin
      v = 1'b1; er = 1'b1;
    end
  endfunction

  function automatic bit model_idle();
    return (m_flush_left == 0) && !m_redir;
  endfunction

  // One clock: compare all outputs with the model mid-cycle, then advance
  // the model on the rising edge using the same inputs.
  task automatic tick(input string tag);
    bit v, er, take;
    logic [4:0] code;
    @(negedge clk);
    model_event(v, er, code);
    take = model_idle() && !rst && v;
    check({tag, ".exc_commit"},  exc_commit,  take && !er);
    check({tag, ".exccode"},     exccode,     (take && !er) ? code : 5'h00);
    check({tag, ".eret_commit"}, eret_commit, take && er);
    check({tag, ".flush"},       flush,       m_flush_left > 0);
    check({tag, ".stall"},       stall,       (m_flush_left > 0) || m_redir);
    check({tag, ".rvalid"},      rvalid,      m_redir);
    check({tag, ".rpc"},         rpc,         m_redir ? m_target : 32'h0);
    @(posedge clk);
    if (rst) begin
      m_flush_left = 0; m_redir = 1'b0; m_target = 32'h0;
    end else if (take) begin
      m_flush_left = FC;
      m_target     = er ? epc : VEC;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
      if (m_flush_left == 0) m_redir = 1'b1;
    end else if (m_redir && rready) begin
      m_redir = 1'b0;
    end
    #1;
  endtask

  task automatic clear_inputs();
    mem_valid = 0; syscall = 0; brk = 0; ovf = 0; adel = 0; ades = 0; eret = 0;
    dslot = 0; pc = 32'h0; status = 32'h0; cause = 32'h0; epc = 32'h0; rready = 1;
  endtask

  // Run idle cycles with ready high until the model is back in IDLE.
  task automatic drain(input string tag);
    int n = 0;
    clear_inputs();
    while (!model_idle() && n < 40) begin
      tick(tag);
      n++;
    end
    check({tag, ".drain_timeout"}, n < 40, 1'b1);
  endtask

  typedef struct {
    logic        mv;
    logic [5:0]  fl;    // {adel, ades, ovf, syscall, brk, eret}
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        exp_commit;
    logic [4:0]  exp_code;
    logic        exp_eret;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic [31:0] hold_pc;

    clear_inputs();
    m_flush_left = 0; m_redir = 1'b0; m_target = 32'h0;
    rst = 1'b1;
    #1;
    tick("reset0");
    tick("reset1");
    rst = 1'b0;
    tick("idle");

    // Single-event vectors applied from IDLE
    tbl[0] = '{1'b1, 6'b000100, 32'h0, 32'h0, 32'h0, 1'b1, 5'h08, 1'b0};
    tbl[1] = '{1'b1, 6'b001010, 32'h0, 32'h0, 32'h0, 1'b1, 5'h0C, 1'b0};
    tbl[2] = '{1'b1, 6'b000001, 32'h0, 32'h0, 32'h80001234, 1'b0, 5'h00, 1'b1};
    tbl[3] = '{1'b1, 6'b110100, 32'h0, 32'h0, 32'h0, 1'b1, 5'h04, 1'b0};
    tbl[4] = '{1'b1, 6'b011000, 32'h0, 32'h0, 32'h0, 1'b1, 5'h05, 1'b0};
    tbl[5] = '{1'b1, 6'b000010, 32'h0, 32'h0, 32'h0, 1'b1, 5'h09, 1'b0};
    tbl[6] = '{1'b1, 6'b000101, 32'h0, 32'h0, 32'h11110000, 1'b1, 5'h08, 1'b0};
    tbl[7] = '{1'b0, 6'b111111, 32'h0, 32'h0, 32'h0, 1'b0, 5'h00, 1'b0};
`ifdef EXC_CTRL_INT_EN
    tbl[8]  = '{1'b0, 6'b000000, 32'h0000FF01, 32'h00000400, 32'h0, 1'b1, 5'h00, 1'b0};
    tbl[10] = '{1'b1, 6'b100000, 32'h0000FF01, 32'h00000400, 32'h0, 1'b1, 5'h00, 1'b0};
`else
    tbl[8]  = '{1'b0, 6'b000000, 32'h0000FF01, 32'h00000400, 32'h0, 1'b0, 5'h00, 1'b0};
    tbl[10] = '{1'b1, 6'b100000, 32'h0000FF01, 32'h00000400, 32'h0, 1'b1, 5'h04, 1'b0};
`endif
    tbl[9]  = '{1'b0, 6'b000000, 32'h0000FF03, 32'h00000400, 32'h0, 1'b0, 5'h00, 1'b0};

    for (int i = 0; i < 11; i++) begin
      clear_inputs();
      mem_valid = tbl[i].mv;
      {adel, ades, ovf, syscall, brk, eret} = tbl[i].fl;
      status = tbl[i].status;
      cause  = tbl[i].cause;
      epc    = tbl[i].epc;
      #2;
      check($sformatf("vec%0d.commit", i), exc_commit,  tbl[i].exp_commit);
      check($sformatf("vec%0d.code", i),   exccode,     tbl[i].exp_code);
      check($sformatf("vec%0d.eret", i),   eret_commit, tbl[i].exp_eret);
      tick($sformatf("vec%0d", i));
      drain($sformatf("vec%0d_drain", i));
    end

    // Syscall timeline: commit, FC flush cycles, redirect on cycle FC+1
    clear_inputs();
    mem_valid = 1; syscall = 1; pc = 32'h80000010;
    #2;
    check("sys.commit", exc_commit, 1'b1);
    check("sys.code", exccode, 5'h08);
    tick("sys_c0");
    clear_inputs();
    for (int c = 1; c <= FC; c++) begin
      #2;
      check($sformatf("sys.flush_c%0d", c), flush, 1'b1);
      check($sformatf("sys.rvalid_c%0d", c), rvalid, 1'b0);
      tick("sys_flush");
    end
    #2;
    check("sys.redirect_valid", rvalid, 1'b1);
    check("sys.redirect_pc", rpc, VEC);
    check("sys.flush_off", flush, 1'b0);
    tick("sys_redir");
    #2;
    check("sys.back_idle", {stall, rvalid}, 2'b00);
    drain("sys_drain");

    // Eret timeline: target is the EPC sampled at the event
    clear_inputs();
    mem_valid = 1; eret = 1; epc = 32'h80001234;
    tick("eret_c0");
    clear_inputs();
    epc = 32'hDEADBEEF;
    for (int c = 0; c < FC; c++) tick("eret_flush");
    #2;
    check("eret.redirect_pc", rpc, 32'h80001234);
    drain("eret_drain");

    // Backpressure: redirect held stable, syscall during REDIRECT ignored
    clear_inputs();
    mem_valid = 1; syscall = 1;
    tick("bp_c0");
    clear_inputs();
    rready = 0;
    for (int c = 0; c < FC; c++) tick("bp_flush");
    hold_pc = VEC;
    for (int c = 0; c < 5; c++) begin
      rready = 0;
      mem_valid = (c == 2); syscall = (c == 2);
      #2;
      check($sformatf("bp.rvalid_c%0d", c), rvalid, 1'b1);
      check($sformatf("bp.rpc_c%0d", c), rpc, hold_pc);
      check($sformatf("bp.no_commit_c%0d", c), exc_commit, 1'b0);
      tick("bp_hold");
    end
    drain("bp_drain");

    // Event coincident with the handshake is taken in the next IDLE cycle
    clear_inputs();
    mem_valid = 1; ovf = 1;
    tick("hs_c0");
    clear_inputs();
    rready = 0;
    for (int c = 0; c < FC; c++) tick("hs_flush");
    rready = 1; mem_valid = 1; syscall = 1;
    #2;
    check("hs.no_commit_in_redirect", exc_commit, 1'b0);
    tick("hs_handshake");
    #2;
    check("hs.commit_next_idle", exc_commit, 1'b1);
    check("hs.code_next_idle", exccode, 5'h08);
    tick("hs_take");
    drain("hs_drain");

    // Reset in the middle of FLUSH
    clear_inputs();
    mem_valid = 1; break_i_set();
    tick("rst_c0");
    clear_inputs();
    rst = 1;
    #2;
    check("rst.flush_before", flush, 1'b1);
    tick("rst_edge");
    rst = 0;
    #2;
    check("rst.outputs_zero",
          {exc_commit, exccode, eret_commit, flush, stall, rvalid, rpc}, 32'h0);
    tick("rst_after");

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      mem_valid = $urandom_range(0, 1);
      syscall   = ($urandom_range(0, 7) == 0);
      brk       = ($urandom_range(0, 7) == 0);
      ovf       = ($urandom_range(0, 7) == 0);
      adel      = ($urandom_range(0, 9) == 0);
      ades      = ($urandom_range(0, 9) == 0);
      eret      = ($urandom_range(0, 5) == 0);
      dslot     = $urandom_range(0, 1);
      pc        = $urandom;
      epc       = $urandom;
      status    = $urandom & 32'h0000FF03;
      cause     = ($urandom_range(0, 7) == 0) ? ($urandom & 32'h0000FF00) : 32'h0;
      rready    = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 63) == 0);
      tick("rand");
    end
    rst = 0;
    drain("rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

  task automatic break_i_set();
    brk = 1;
  endtask

endmodule
